// File: rtl/jtag_vnode_hub_pkg.sv
// ---------------------------------------------------------------------------
// jtag_vnode_pkg
// Shared definitions for the multi-node virtual JTAG hub and the TAP
// controller it is built on.
//   tap_state_e     : the sixteen IEEE 1149.1 TAP controller states; each
//                     enum value is also that state's bit position in the
//                     one-hot jtag_state vector.
//   IDX_*           : one-hot bit positions, named for readability at the
//                     decode sites.
//   BYPASS etc.     : 10-bit TAP instruction constants.
//   clog2()         : ceiling log2, used to size the node select field.
// ---------------------------------------------------------------------------
package jtag_vnode_pkg;

    typedef enum logic [3:0] {
        TLR  = 4'd0,
        RTI  = 4'd1,
        SDRS = 4'd2,
        CDR  = 4'd3,
        SDR  = 4'd4,
        E1DR = 4'd5,
        PDR  = 4'd6,
        E2DR = 4'd7,
        UDR  = 4'd8,
        SIRS = 4'd9,
        CIR  = 4'd10,
        SIR  = 4'd11,
        E1IR = 4'd12,
        PIR  = 4'd13,
        E2IR = 4'd14,
        UIR  = 4'd15
    } tap_state_e;

    localparam int IDX_TLR  = 0;
    localparam int IDX_RTI  = 1;
    localparam int IDX_SDRS = 2;
    localparam int IDX_CDR  = 3;
    localparam int IDX_SDR  = 4;
    localparam int IDX_E1DR = 5;
    localparam int IDX_PDR  = 6;
    localparam int IDX_E2DR = 7;
    localparam int IDX_UDR  = 8;
    localparam int IDX_SIRS = 9;
    localparam int IDX_CIR  = 10;
    localparam int IDX_SIR  = 11;
    localparam int IDX_E1IR = 12;
    localparam int IDX_PIR  = 13;
    localparam int IDX_E2IR = 14;
    localparam int IDX_UIR  = 15;

    localparam logic [9:0] BYPASS        = 10'h3FF;
    localparam logic [9:0] IR_CAPTURE    = 10'h001;
    localparam logic [9:0] USER0_DEFAULT = 10'h00C;
    localparam logic [9:0] USER1_DEFAULT = 10'h00E;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jtag_vnode_hub_if.sv
// ---------------------------------------------------------------------------
// jtag_vnode_hub_if
// Bundles every non-clock signal of the virtual JTAG hub: the transactor
// side (tms/tdi/tdo), the per-node side (node_tdo, node_ir_out, node_ir_in
// and the virtual state strobes) and the TAP observation outputs
// (jtag_state, tap_ir).
//   modport slave  : the hub's view.
//   modport master : the view of whatever drives the hub (transactor plus
//                    the debug nodes).
// ---------------------------------------------------------------------------
interface jtag_vnode_hub_if #(
    parameter int N_NODES       = 2,
    parameter int NODE_IR_WIDTH = 4,
    parameter int TAP_IR_WIDTH  = 10
);

    logic                               tms;
    logic                               tdi;
    logic                               tdo;
    logic [N_NODES-1:0]                 node_tdo;
    logic [N_NODES*NODE_IR_WIDTH-1:0]   node_ir_out;
    logic [N_NODES*NODE_IR_WIDTH-1:0]   node_ir_in;
    logic [N_NODES-1:0]                 virtual_state_cdr;
    logic [N_NODES-1:0]                 virtual_state_sdr;
    logic [N_NODES-1:0]                 virtual_state_e1dr;
    logic [N_NODES-1:0]                 virtual_state_pdr;
    logic [N_NODES-1:0]                 virtual_state_e2dr;
    logic [N_NODES-1:0]                 virtual_state_udr;
    logic [N_NODES-1:0]                 virtual_state_cir;
    logic [N_NODES-1:0]                 virtual_state_uir;
    logic [15:0]                        jtag_state;
    logic [TAP_IR_WIDTH-1:0]            tap_ir;

    modport slave (
        input  tms, tdi, node_tdo, node_ir_out,
        output tdo, node_ir_in,
               virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
               virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
               virtual_state_cir, virtual_state_uir,
               jtag_state, tap_ir
    );

    modport master (
        output tms, tdi, node_tdo, node_ir_out,
        input  tdo, node_ir_in,
               virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
               virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
               virtual_state_cir, virtual_state_uir,
               jtag_state, tap_ir
    );

endinterface

// File: rtl/jtag_vnode_hub_tap_fsm.sv
// ---------------------------------------------------------------------------
// jtag_tap_fsm
// IEEE 1149.1 TAP controller. Shared by the ASE JTAG models, so it knows
// nothing about instructions or data registers.
//   tck     in   JTAG clock, state advances on the rising edge
//   trst_n  in   asynchronous active-low reset to Test-Logic-Reset
//   tms_i   in   test mode select
//   state_o out  one-hot TAP state, bit index = tap_state_e value
// ---------------------------------------------------------------------------
module jtag_tap_fsm
    import jtag_vnode_pkg::*;
(
    input  logic        tck,
    input  logic        trst_n,
    input  logic        tms_i,
    output logic [15:0] state_o
);

    tap_state_e  state_q;
    tap_state_e  state_d;
    logic [15:0] onehot_q;

    // Standard TAP transition graph.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms_i ? TLR  : RTI;
            RTI:     state_d = tms_i ? SDRS : RTI;
            SDRS:    state_d = tms_i ? SIRS : CDR;
            CDR:     state_d = tms_i ? E1DR : SDR;
            SDR:     state_d = tms_i ? E1DR : SDR;
            E1DR:    state_d = tms_i ? UDR  : PDR;
            PDR:     state_d = tms_i ? E2DR : PDR;
            E2DR:    state_d = tms_i ? UDR  : SDR;
            UDR:     state_d = tms_i ? SDRS : RTI;
            SIRS:    state_d = tms_i ? TLR  : CIR;
            CIR:     state_d = tms_i ? E1IR : SIR;
            SIR:     state_d = tms_i ? E1IR : SIR;
            E1IR:    state_d = tms_i ? UIR  : PIR;
            PIR:     state_d = tms_i ? E2IR : PIR;
            E2IR:    state_d = tms_i ? UIR  : SIR;
            UIR:     state_d = tms_i ? SDRS : RTI;
            default: state_d = TLR;
        endcase
    end

    // The one-hot view is registered alongside the encoded state so every
    // consumer decodes a flop output rather than a comparator.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            state_q  <= TLR;
            onehot_q <= 16'h0001;
        end else begin
            state_q  <= state_d;
            onehot_q <= 16'h0001 << state_d;
        end
    end

    assign state_o = onehot_q;

endmodule

// File: rtl/jtag_vnode_hub.sv
// ---------------------------------------------------------------------------
// jtag_vnode_hub
// Virtual JTAG hub: one TAP with a 10-bit instruction register fanned out to
// N_NODES debug nodes. USER1 scans a {sel, ir} virtual IR that picks the
// active node and writes its IR; USER0 routes DR scans to the active node;
// every other instruction sees a 1-bit bypass register.
//   tck, trst_n      clock and asynchronous active-low reset
//   bus.tms/tdi/tdo  serial JTAG pins from the transactor
//   bus.node_tdo     per-node DR serial output
//   bus.node_ir_out  per-node IR value captured in USER1 Capture-DR
//   bus.node_ir_in   per-node latched virtual IR
//   bus.virtual_state_*  per-node state strobes
//   bus.jtag_state   one-hot TAP state
//   bus.tap_ir       current TAP instruction
// ---------------------------------------------------------------------------
module jtag_vnode_hub
    import jtag_vnode_pkg::*;
#(
    parameter int                      N_NODES       = 2,
    parameter int                      NODE_IR_WIDTH = 4,
    parameter int                      TAP_IR_WIDTH  = 10,
    parameter logic [TAP_IR_WIDTH-1:0] USER0_CODE    = TAP_IR_WIDTH'(USER0_DEFAULT),
    parameter logic [TAP_IR_WIDTH-1:0] USER1_CODE    = TAP_IR_WIDTH'(USER1_DEFAULT)
) (
    input  logic             tck,
    input  logic             trst_n,
    jtag_vnode_hub_if.slave  bus
);

    localparam int SEL_RAW = clog2(N_NODES);
    localparam int SEL_W   = (SEL_RAW < 1) ? 1 : SEL_RAW;
    localparam int NIW     = NODE_IR_WIDTH;
    localparam int VIR_W   = SEL_W + NIW;

    localparam logic [TAP_IR_WIDTH-1:0] IR_BYPASS = TAP_IR_WIDTH'(BYPASS);
    localparam logic [TAP_IR_WIDTH-1:0] IR_CAP    = TAP_IR_WIDTH'(IR_CAPTURE);
    // One extra bit so N_NODES = 2**SEL_W still fits for the range check.
    localparam logic [SEL_W:0]          SEL_LIMIT = (SEL_W+1)'(N_NODES);

    logic [15:0]              js;
    logic [TAP_IR_WIDTH-1:0]  tap_ir_q, tap_ir_d;
    logic [TAP_IR_WIDTH-1:0]  ir_sr_q, ir_sr_d;
    logic [VIR_W-1:0]         vir_sr_q, vir_sr_d;
    logic                     byp_q, byp_d;
    logic [SEL_W-1:0]         cur_sel_q, cur_sel_d;
    logic [N_NODES*NIW-1:0]   node_ir_q, node_ir_d;

    logic                     is_user0, is_user1, enter_tlr, uir_fire;
    logic [SEL_W-1:0]         vir_sel;
    logic [NIW-1:0]           vir_ir;
    logic                     sel_node_tdo;
    logic [NIW-1:0]           sel_node_ir;
    logic                     tdo_c;
    logic [N_NODES-1:0]       vs_cdr, vs_sdr, vs_e1dr, vs_pdr, vs_e2dr, vs_udr, vs_cir, vs_uir;

    jtag_tap_fsm u_tap_fsm (
        .tck     (tck),
        .trst_n  (trst_n),
        .tms_i   (bus.tms),
        .state_o (js)
    );

    assign is_user0 = (tap_ir_q == USER0_CODE);
    assign is_user1 = (tap_ir_q == USER1_CODE);
    // Only Select-IR-Scan with tms=1 enters TLR from outside it; while
    // sitting in TLR the reset values are simply re-applied.
    assign enter_tlr = js[IDX_TLR] | (js[IDX_SIRS] & bus.tms);
    assign vir_sel   = vir_sr_q[VIR_W-1 -: SEL_W];
    assign vir_ir    = vir_sr_q[NIW-1:0];
    // Selects beyond the last node are dropped so a stray scan cannot point
    // the hub at a node that does not exist.
    assign uir_fire  = is_user1 & js[IDX_UDR] & ({1'b0, vir_sel} < SEL_LIMIT);

    // Active-node views of the node-side inputs. Written as a compare loop
    // so a non-power-of-two node count never indexes past the vectors.
    always_comb begin
        sel_node_tdo = 1'b0;
        sel_node_ir  = '0;
        for (int n = 0; n < N_NODES; n++) begin
            if (cur_sel_q == SEL_W'(n)) begin
                sel_node_tdo = bus.node_tdo[n];
                sel_node_ir  = bus.node_ir_out[n*NIW +: NIW];
            end
        end
    end

    // Instruction path: capture the fixed 0..01 pattern, shift LSB first,
    // commit in Update-IR. Entering TLR forces BYPASS and node 0.
    always_comb begin
        ir_sr_d   = ir_sr_q;
        tap_ir_d  = tap_ir_q;
        cur_sel_d = cur_sel_q;
        if (js[IDX_CIR]) begin
            ir_sr_d = IR_CAP;
        end else if (js[IDX_SIR]) begin
            ir_sr_d = {bus.tdi, ir_sr_q[TAP_IR_WIDTH-1:1]};
        end
        if (enter_tlr) begin
            tap_ir_d  = IR_BYPASS;
            cur_sel_d = '0;
        end else if (js[IDX_UIR]) begin
            tap_ir_d = ir_sr_q;
        end else if (uir_fire) begin
            cur_sel_d = vir_sel;
        end
    end

    // Data path: USER1 owns the virtual IR shifter, USER0 has no local
    // register (the node shifts), everything else shifts through bypass.
    always_comb begin
        vir_sr_d  = vir_sr_q;
        byp_d     = byp_q;
        node_ir_d = node_ir_q;
        if (is_user1) begin
            if (js[IDX_CDR]) begin
                vir_sr_d = {cur_sel_q, sel_node_ir};
            end else if (js[IDX_SDR]) begin
                vir_sr_d = {bus.tdi, vir_sr_q[VIR_W-1:1]};
            end
        end else if (!is_user0) begin
            if (js[IDX_CDR]) begin
                byp_d = 1'b0;
            end else if (js[IDX_SDR]) begin
                byp_d = bus.tdi;
            end
        end
        for (int n = 0; n < N_NODES; n++) begin
            if (uir_fire && (vir_sel == SEL_W'(n))) begin
                node_ir_d[n*NIW +: NIW] = vir_ir;
            end
        end
    end

    // All hub state, reset together so a mid-scan trst_n leaves no partial
    // update behind.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            tap_ir_q  <= IR_BYPASS;
            ir_sr_q   <= '0;
            vir_sr_q  <= '0;
            byp_q     <= 1'b0;
            cur_sel_q <= '0;
            node_ir_q <= '0;
        end else begin
            tap_ir_q  <= tap_ir_d;
            ir_sr_q   <= ir_sr_d;
            vir_sr_q  <= vir_sr_d;
            byp_q     <= byp_d;
            cur_sel_q <= cur_sel_d;
            node_ir_q <= node_ir_d;
        end
    end

    // Strobes go only to the active node, except uir which flags the node
    // being written (it may differ from the current selection).
    always_comb begin
        vs_cdr  = '0;
        vs_sdr  = '0;
        vs_e1dr = '0;
        vs_pdr  = '0;
        vs_e2dr = '0;
        vs_udr  = '0;
        vs_cir  = '0;
        vs_uir  = '0;
        for (int n = 0; n < N_NODES; n++) begin
            if (cur_sel_q == SEL_W'(n)) begin
                if (is_user0) begin
                    vs_cdr[n]  = js[IDX_CDR];
                    vs_sdr[n]  = js[IDX_SDR];
                    vs_e1dr[n] = js[IDX_E1DR];
                    vs_pdr[n]  = js[IDX_PDR];
                    vs_e2dr[n] = js[IDX_E2DR];
                    vs_udr[n]  = js[IDX_UDR];
                end
                if (is_user1) begin
                    vs_cir[n] = js[IDX_CDR];
                end
            end
            if (uir_fire && (vir_sel == SEL_W'(n))) begin
                vs_uir[n] = 1'b1;
            end
        end
    end

    // tdo follows registered state only (plus the node's own tdo under
    // USER0), so it moves just after the rising edge.
    always_comb begin
        tdo_c = 1'b0;
        if (js[IDX_SIR]) begin
            tdo_c = ir_sr_q[0];
        end else if (js[IDX_SDR]) begin
            if (is_user1) begin
                tdo_c = vir_sr_q[0];
            end else if (is_user0) begin
                tdo_c = sel_node_tdo;
            end else begin
                tdo_c = byp_q;
            end
        end
    end

    assign bus.tdo                = tdo_c;
    assign bus.node_ir_in         = node_ir_q;
    assign bus.jtag_state         = js;
    assign bus.tap_ir             = tap_ir_q;
    assign bus.virtual_state_cdr  = vs_cdr;
    assign bus.virtual_state_sdr  = vs_sdr;
    assign bus.virtual_state_e1dr = vs_e1dr;
    assign bus.virtual_state_pdr  = vs_pdr;
    assign bus.virtual_state_e2dr = vs_e2dr;
    assign bus.virtual_state_udr  = vs_udr;
    assign bus.virtual_state_cir  = vs_cir;
    assign bus.virtual_state_uir  = vs_uir;

endmodule

// File: tb/tb_jtag_vnode_hub.sv
// ---------------------------------------------------------------------------
// tb_jtag_vnode_hub
// Two hubs: dutA (2 nodes x 4-bit IR) follows a behavioural model every
// cycle; dutB (3 nodes) exercises the out-of-range select with literal
// expectations. Inputs change 2 time units after the rising edge, outputs
// are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_jtag_vnode_hub;

    localparam int U0 = 12;
    localparam int U1 = 14;

    logic tck = 1'b0;
    logic trst_n;
    logic useB;

    int compared   = 0;
    int mismatched = 0;

    always #5 tck = ~tck;

    jtag_vnode_hub_if #(.N_NODES(2), .NODE_IR_WIDTH(4), .TAP_IR_WIDTH(10)) busA ();
    jtag_vnode_hub_if #(.N_NODES(3), .NODE_IR_WIDTH(4), .TAP_IR_WIDTH(10)) busB ();

    jtag_vnode_hub #(.N_NODES(2), .NODE_IR_WIDTH(4), .TAP_IR_WIDTH(10)) dutA (
        .tck    (tck),
        .trst_n (trst_n),
        .bus    (busA)
    );

    jtag_vnode_hub #(.N_NODES(3), .NODE_IR_WIDTH(4), .TAP_IR_WIDTH(10)) dutB (
        .tck    (tck),
        .trst_n (trst_n),
        .bus    (busB)
    );

    // Single comparison point shared by the model compare and the literal checks.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared = compared + 1;
        if (act !== exp) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // TAP transition tables indexed by state number (TLR=0 ... UIR=15).
    int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    int mSt, mIrSr, mTapIr, mVir, mByp, mSel;
    int mNodeIr[2];

    // Behavioural model of dutA: plain integers for every register the hub
    // exposes or shifts.
    always @(posedge tck or negedge trst_n) begin : modelUpdate
        int nx, d, s, cap;
        if (!trst_n) begin
            mSt = 0; mIrSr = 0; mTapIr = 1023; mVir = 0; mByp = 0; mSel = 0;
            mNodeIr[0] = 0; mNodeIr[1] = 0;
        end else begin
            d  = busA.tdi ? 1 : 0;
            nx = busA.tms ? nxt1[mSt] : nxt0[mSt];
            case (mSt)
                10: mIrSr = 1;
                11: mIrSr = (mIrSr >> 1) | (d << 9);
                15: mTapIr = mIrSr;
                3: begin
                    if (mTapIr == U1) begin
                        cap  = (int'(busA.node_ir_out) >> (4 * mSel)) & 15;
                        mVir = (mSel << 4) | cap;
                    end else if (mTapIr != U0) begin
                        mByp = 0;
                    end
                end
                4: begin
                    if (mTapIr == U1) mVir = (mVir >> 1) | (d << 4);
                    else if (mTapIr != U0) mByp = d;
                end
                8: begin
                    if (mTapIr == U1) begin
                        s = mVir >> 4;
                        if (s < 2) begin
                            mSel = s;
                            mNodeIr[s] = mVir & 15;
                        end
                    end
                end
                default: ;
            endcase
            if (nx == 0) begin
                mTapIr = 1023;
                mSel   = 0;
            end
            mSt = nx;
        end
    end

    // Every falling edge: all dutA outputs against the model.
    always @(negedge tck) begin : modelCompare
        int selBit, vSel, expTdo, dr0, dr1;
        selBit = 1 << mSel;
        vSel   = mVir >> 4;
        dr0    = (mTapIr == U0) ? selBit : 0;
        dr1    = (mTapIr == U1) ? selBit : 0;
        expTdo = 0;
        if (mSt == 11) expTdo = mIrSr & 1;
        else if (mSt == 4) begin
            if (mTapIr == U1) expTdo = mVir & 1;
            else if (mTapIr == U0) expTdo = (int'(busA.node_tdo) >> mSel) & 1;
            else expTdo = mByp;
        end
        checkOutput("m_jtag_state", busA.jtag_state, 32'(1) << mSt);
        checkOutput("m_tap_ir", busA.tap_ir, mTapIr);
        checkOutput("m_tdo", busA.tdo, expTdo);
        checkOutput("m_node_ir_in", busA.node_ir_in, (mNodeIr[1] << 4) | mNodeIr[0]);
        checkOutput("m_vs_cdr",  busA.virtual_state_cdr,  (mSt == 3) ? dr0 : 0);
        checkOutput("m_vs_sdr",  busA.virtual_state_sdr,  (mSt == 4) ? dr0 : 0);
        checkOutput("m_vs_e1dr", busA.virtual_state_e1dr, (mSt == 5) ? dr0 : 0);
        checkOutput("m_vs_pdr",  busA.virtual_state_pdr,  (mSt == 6) ? dr0 : 0);
        checkOutput("m_vs_e2dr", busA.virtual_state_e2dr, (mSt == 7) ? dr0 : 0);
        checkOutput("m_vs_udr",  busA.virtual_state_udr,  (mSt == 8) ? dr0 : 0);
        checkOutput("m_vs_cir",  busA.virtual_state_cir,  (mSt == 3) ? dr1 : 0);
        checkOutput("m_vs_uir",  busA.virtual_state_uir,
                    (mTapIr == U1 && mSt == 8 && vSel < 2) ? (1 << vSel) : 0);
    end

    // Observation helpers for whichever hub is being driven.
    function automatic logic obsTdo();
        return useB ? busB.tdo : busA.tdo;
    endfunction
    function automatic logic [2:0] obsUir();
        return useB ? busB.virtual_state_uir : {1'b0, busA.virtual_state_uir};
    endfunction
    function automatic logic [2:0] obsCir();
        return useB ? busB.virtual_state_cir : {1'b0, busA.virtual_state_cir};
    endfunction
    function automatic logic [2:0] obsSdr();
        return useB ? busB.virtual_state_sdr : {1'b0, busA.virtual_state_sdr};
    endfunction
    function automatic logic [11:0] obsNodeIr();
        return useB ? busB.node_ir_in : {4'h0, busA.node_ir_in};
    endfunction

    // One tck cycle on the selected hub; the idle hub is parked in TLR.
    task automatic applyStimulus(input logic t, input logic d);
        if (useB) begin
            busB.tms = t; busB.tdi = d; busA.tms = 1'b1; busA.tdi = 1'b0;
        end else begin
            busA.tms = t; busA.tdi = d; busB.tms = 1'b1; busB.tdi = 1'b0;
        end
        @(posedge tck);
        #2;
    endtask

    logic [9:0]  irTdo;
    logic [31:0] drTdo;
    logic [2:0]  cdrCir, udrUir, postUir, sdrSeen;
    logic [11:0] udrNodeIr;

    // RTI -> IR scan (LSB first) -> RTI, recording tdo while shifting.
    task automatic irScan(input logic [9:0] code);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            irTdo[i] = obsTdo();
            applyStimulus(i == 9, code[i]);
        end
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    // RTI -> DR scan of width bits -> RTI, recording tdo and strobes.
    task automatic drScan(input int width, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        cdrCir  = obsCir();
        applyStimulus(1'b0, 1'b0);
        sdrSeen = 3'b000;
        drTdo   = '0;
        for (int i = 0; i < width; i++) begin
            drTdo[i] = obsTdo();
            sdrSeen  = sdrSeen | obsSdr();
            applyStimulus(i == width - 1, data[i]);
        end
        applyStimulus(1'b1, 1'b0);
        udrUir    = obsUir();
        udrNodeIr = obsNodeIr();
        applyStimulus(1'b0, 1'b0);
        postUir   = obsUir();
    endtask

    initial begin
        useB             = 1'b0;
        trst_n           = 1'b0;
        busA.tms         = 1'b1; busA.tdi = 1'b0;
        busB.tms         = 1'b1; busB.tdi = 1'b0;
        busA.node_tdo    = 2'b00;
        busA.node_ir_out = 8'h53;
        busB.node_tdo    = 3'b000;
        busB.node_ir_out = 12'h961;
        repeat (2) @(posedge tck);
        #2;
        checkOutput("rst_state", busA.jtag_state, 16'h0001);
        checkOutput("rst_tap_ir", busA.tap_ir, 10'h3FF);
        checkOutput("rst_tdo", busA.tdo, 1'b0);
        trst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("rti_state", busA.jtag_state, 16'h0002);

        $display("[TB] IR capture and USER1 load");
        irScan(10'h00E);
        checkOutput("ir_capture_tdo", irTdo[1:0], 2'b01);
        checkOutput("tap_ir_user1", busA.tap_ir, 10'h00E);
        drScan(5, 32'h1A);
        checkOutput("vir_capture_sel0", drTdo[4:0], 5'h03);
        checkOutput("uir_strobe", udrUir, 3'b010);
        checkOutput("uir_one_cycle", postUir, 3'b000);
        checkOutput("ir_in_at_udr", udrNodeIr, 12'h000);
        checkOutput("ir_in_after_udr", busA.node_ir_in, 8'hA0);

        $display("[TB] capture readback");
        busA.node_ir_out = 8'h53;
        drScan(5, 32'h15);
        checkOutput("readback_tdo", drTdo[4:0], 5'h15);
        checkOutput("cir_strobe", cdrCir, 3'b010);

        $display("[TB] USER0 routing");
        busA.node_tdo = 2'b10;
        irScan(10'h00C);
        checkOutput("tap_ir_user0", busA.tap_ir, 10'h00C);
        drScan(8, 32'h0);
        checkOutput("user0_tdo", drTdo[7:0], 8'hFF);
        checkOutput("user0_sdr_strobe", sdrSeen, 3'b010);

        $display("[TB] bypass");
        irScan(10'h3FF);
        drScan(32, 32'hA5C31E69);
        checkOutput("bypass_delay", drTdo, 32'h4B863CD2);

        $display("[TB] reset mid-SDR");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("in_sdr", busA.jtag_state, 16'h0010);
        trst_n = 1'b0;
        #1;
        checkOutput("abort_state", busA.jtag_state, 16'h0001);
        checkOutput("abort_tap_ir", busA.tap_ir, 10'h3FF);
        checkOutput("abort_node_ir", busA.node_ir_in, 8'h00);
        checkOutput("abort_tdo", busA.tdo, 1'b0);
        @(posedge tck);
        #2;
        trst_n = 1'b1;

        $display("[TB] five tms=1 to TLR");
        applyStimulus(1'b0, 1'b0);
        irScan(10'h00E);
        drScan(5, 32'h1A);
        repeat (5) applyStimulus(1'b1, 1'b0);
        checkOutput("tms5_state", busA.jtag_state, 16'h0001);
        checkOutput("tms5_tap_ir", busA.tap_ir, 10'h3FF);
        checkOutput("tms5_node_ir_kept", busA.node_ir_in, 8'hA0);

        $display("[TB] out-of-range select, 3 nodes");
        useB = 1'b1;
        applyStimulus(1'b0, 1'b0);
        irScan(10'h00E);
        drScan(6, 32'h27);
        checkOutput("b_capture0", drTdo[5:0], 6'h01);
        checkOutput("b_uir_sel2", udrUir, 3'b100);
        checkOutput("b_node_ir", busB.node_ir_in, 12'h700);
        drScan(6, 32'h3F);
        checkOutput("b_capture_sel2", drTdo[5:0], 6'h29);
        checkOutput("b_uir_sel3", udrUir, 3'b000);
        checkOutput("b_uir_sel3_post", postUir, 3'b000);
        checkOutput("b_node_ir_kept", busB.node_ir_in, 12'h700);
        drScan(6, 32'h29);
        checkOutput("b_sel_kept_cir", cdrCir, 3'b100);
        checkOutput("b_sel_kept_tdo", drTdo[5:0], 6'h29);

        @(negedge tck);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
